btn_debounce: RTL



---
 rtl/btn_debounce.sv | 88 ++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, per-bit stability counter, press/release pulses, toggle.
// Latency sync + STABLE_CYCLES edges from pin capture to level change; free-running, no backpressure.
module btn_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1250000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_toggle
);

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
      $error("btn_debounce: STABLE_CYCLES must be 2 or more");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            level_q, level_d;
  logic [WIDTH-1:0]            press_q, press_d;
  logic [WIDTH-1:0]            release_q, release_d;
  logic [WIDTH-1:0]            toggle_q, toggle_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Pure flop-to-flop synchroniser; nothing may sit between the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    toggle_d  = toggle_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        // Any bounce back to the accepted level restarts the full interval.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
        if (sync2_q[i]) begin
          toggle_d[i] = ~toggle_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_toggle  = toggle_q;

endmodule
